// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper: drives every N_IN-bit input vector to a combinational
// DUT in ascending order, holds each for HOLD cycles, samples the DUT output
// in the last cycle of each window and checks it against the EXPECT table.
// Optional build macro: TT_CAPTURE_EN adds the captured_tt output holding the
// measured truth table of the last sweep.
module truth_table_sweeper #(
   parameter int unsigned         N_IN   = 4,
   parameter int unsigned         HOLD   = 20,
   parameter logic [2**N_IN-1:0]  EXPECT = '0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   output logic [N_IN-1:0]   dut_in,
   input  logic              dut_out,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic [N_IN:0]     err_count,
   output logic [N_IN-1:0]   first_err_vec,
   output logic              err_seen
`ifdef TT_CAPTURE_EN
   ,
   output logic [2**N_IN-1:0] captured_tt
`endif
);

   localparam int unsigned ERR_W = N_IN + 1;
   localparam int unsigned CNT_W = (HOLD > 1) ? $clog2(HOLD) : 1;

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] APPLY = 2'd1;
   localparam logic [1:0] DONE  = 2'd2;

   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD - 1);
   localparam logic [N_IN-1:0]  VEC_LAST  = '1;

   logic [1:0]       state, state_nxt;
   logic [CNT_W-1:0] hold_cnt, hold_cnt_nxt;
   logic [N_IN-1:0]  dut_in_nxt;
   logic             busy_nxt;
   logic             done_nxt;
   logic             pass_nxt;
   logic [N_IN:0]    err_count_nxt;
   logic [N_IN-1:0]  first_err_vec_nxt;
   logic             err_seen_nxt;
`ifdef TT_CAPTURE_EN
   logic [2**N_IN-1:0] captured_tt_nxt;
`endif

   // State and result registers; reset aborts any sweep and clears all results.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         hold_cnt      <= '0;
         dut_in        <= '0;
         busy          <= 1'b0;
         done          <= 1'b0;
         pass          <= 1'b0;
         err_count     <= '0;
         first_err_vec <= '0;
         err_seen      <= 1'b0;
`ifdef TT_CAPTURE_EN
         captured_tt   <= '0;
`endif
      end else begin
         state         <= state_nxt;
         hold_cnt      <= hold_cnt_nxt;
         dut_in        <= dut_in_nxt;
         busy          <= busy_nxt;
         done          <= done_nxt;
         pass          <= pass_nxt;
         err_count     <= err_count_nxt;
         first_err_vec <= first_err_vec_nxt;
         err_seen      <= err_seen_nxt;
`ifdef TT_CAPTURE_EN
         captured_tt   <= captured_tt_nxt;
`endif
      end
   end

   // Next-state and next-result logic: accept start when idle/done, step
   // through vectors, compare on the last cycle of each hold window.
   always_comb begin
      state_nxt         = state;
      hold_cnt_nxt      = hold_cnt;
      dut_in_nxt        = dut_in;
      busy_nxt          = busy;
      done_nxt          = done;
      pass_nxt          = pass;
      err_count_nxt     = err_count;
      first_err_vec_nxt = first_err_vec;
      err_seen_nxt      = err_seen;
`ifdef TT_CAPTURE_EN
      captured_tt_nxt   = captured_tt;
`endif

      case (state)
         IDLE, DONE: begin
            if (start) begin
               state_nxt         = APPLY;
               hold_cnt_nxt      = '0;
               dut_in_nxt        = '0;
               busy_nxt          = 1'b1;
               done_nxt          = 1'b0;
               pass_nxt          = 1'b0;
               err_count_nxt     = '0;
               first_err_vec_nxt = '0;
               err_seen_nxt      = 1'b0;
`ifdef TT_CAPTURE_EN
               captured_tt_nxt   = '0;
`endif
            end
         end

         APPLY: begin
            if (hold_cnt == HOLD_LAST) begin
`ifdef TT_CAPTURE_EN
               captured_tt_nxt[dut_in] = dut_out;
`endif
               if (dut_out != EXPECT[dut_in]) begin
                  err_count_nxt = err_count + ERR_W'(1);
                  if (!err_seen) begin
                     first_err_vec_nxt = dut_in;
                     err_seen_nxt      = 1'b1;
                  end
               end
               if (dut_in == VEC_LAST) begin
                  state_nxt = DONE;
                  busy_nxt  = 1'b0;
                  done_nxt  = 1'b1;
                  pass_nxt  = (err_count_nxt == '0);
               end else begin
                  dut_in_nxt   = dut_in + N_IN'(1);
                  hold_cnt_nxt = '0;
               end
            end else begin
               hold_cnt_nxt = hold_cnt + CNT_W'(1);
            end
         end

         default: state_nxt = IDLE;
      endcase
   end

endmodule

// File: doc/truth_table_sweeper.md
Name: truth_table_sweeper

Overview:
- Hardware successor to the hand-written 4-input exhaustive stimulus benches.
- Sweeps N_IN DUT inputs through all 2^N_IN combinations in ascending binary order, holding each vector for HOLD cycles.
- Samples the single-bit DUT output at the end of each hold window and compares it against a parametrised expected truth table.
- Reports pass/fail, mismatch count and first failing vector, so combinational lab blocks can be checked on-chip or in a self-checking bench.

Parameters:
- N_IN, 4, number of DUT inputs (1..8).
- HOLD, 20, clock cycles each vector is held (>=1).
- EXPECT, 16'h0000, expected output truth table, width 2^N_IN; bit k = expected f for input vector k.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  single-cycle pulse; begins a sweep when not busy.
- dut_in  output  N_IN  vector driven to DUT; MSB = x1, LSB = xN.
- dut_out  input  1  DUT output f.
- busy  output  1  high while sweeping.
- done  output  1  high from sweep completion until next accepted start.
- pass  output  1  valid when done; 1 iff err_count==0.
- err_count  output  N_IN+1  number of mismatching vectors in the last or current sweep.
- first_err_vec  output  N_IN  index of the first mismatching vector.
- err_seen  output  1  at least one mismatch this sweep; qualifies first_err_vec.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; dut_in=0, busy=0, done=0, pass=0, err_count=0, first_err_vec=0, err_seen=0; hold counter=0. Reset mid-sweep aborts immediately. No partial results are retained.
- States: IDLE, APPLY, DONE.
- IDLE: start=1 -> APPLY. On that edge: dut_in=0, hold_cnt=0, err_count=0, err_seen=0, first_err_vec=0, busy=1, done=0, pass=0.
- APPLY: hold_cnt increments each cycle. On the cycle where hold_cnt==HOLD-1, sample dut_out and compare with EXPECT[dut_in].
  - Mismatch: err_count+1. If err_seen=0, set first_err_vec=dut_in and err_seen=1.
  - Same edge, if dut_in==2^N_IN-1 -> DONE: busy=0, done=1, pass=(final err_count==0), including the mismatch just counted. dut_in holds its last value.
  - Otherwise dut_in+1 and hold_cnt=0.
- Timing: the first vector is presented in the cycle after start is accepted. Each vector is stable for exactly HOLD cycles. Total busy = 2^N_IN*HOLD cycles.
- DUT output must settle within HOLD-1 cycles; sampling uses the last cycle of the window.
- DONE: outputs hold. start=1 -> restart exactly as from IDLE (results cleared). done deasserts on the same edge busy asserts.
- start while busy (APPLY) is ignored. No queued restart.
- err_count max = 2^N_IN, which fits in N_IN+1 bits; no saturation logic needed.
- HOLD=1: every cycle is a sample cycle; hold_cnt stays 0.
- dut_out is assumed synchronous to clk; no synchroniser.

Optional Feature:
- Macro: TT_CAPTURE_EN.
- Defined:
  - Adds output captured_tt, width 2^N_IN, reset 0.
  - On each sample edge, bit dut_in is written with the sampled dut_out.
  - Cleared on accepted start.
  - After done, it holds the DUT's full measured truth table. XOR with EXPECT gives the mismatch map.
- Not defined: port and register absent; all other behaviour identical.

Test Plan:
- N_IN=4, HOLD=2, EXPECT=16'hA5C3; bench model drives dut_out=EXPECT[dut_in]; pulse start -> dut_in steps 0..15, each held 2 cycles; busy high 32 cycles; done=1, pass=1, err_count=0, err_seen=0.
- Same config, model inverts output only at vector 5 -> err_count=1, err_seen=1, first_err_vec=5, pass=0.
- Model drives ~EXPECT[dut_in] for all vectors -> err_count=16 (5'b10000), first_err_vec=0, pass=0.
- Pulse start again at vector 3 mid-sweep -> ignored, sweep completes at its original time. Then start in DONE -> results cleared, new sweep runs, done low during it.
- Assert rst_n=0 while dut_in=7 with one error already counted -> all outputs 0 immediately (asynchronous, before next clk edge). After release and start, sweep restarts at vector 0.
- With TT_CAPTURE_EN defined and the vector-5 error model -> captured_tt=16'hA5C3^16'h0020=16'hA5E3 at done.
